// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Owns the program counter. It fetches one instruction word per request from
//   the control unit and delivers it to the instruction register. A fetch reads
//   the instruction memory at PC, waits IM_LATENCY cycles, presents the word on
//   out_to_IR, pulses loadIR for one cycle, and then advances PC. The unit also
//   supports jumps (PC load) and a sticky halt.
//
// Ports:
//   clk          in   system clock; all state updates on the rising edge
//   reset        in   synchronous, active-high reset
//   fetch_en     in   request for the next instruction (sampled only in IDLE)
//   pc_load      in   load PC with pc_load_addr (jump/branch)
//   pc_load_addr in   jump target
//   halt         in   stop fetching; sticky until reset
//   im_data      in   instruction memory read data
//   im_addr      out  instruction memory address (always equals pc)
//   im_rd        out  instruction memory read strobe (high in ISSUE only)
//   out_to_IR    out  captured instruction word for the IR
//   loadIR       out  one-cycle IR load strobe
//   pc           out  current program counter
//   busy         out  fetch in progress (ISSUE, WAIT, LOAD)
//   halted       out  unit is in HALTED
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 16,
   parameter int IM_LATENCY = 1,
   parameter int RESET_PC   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_addr,
   input  logic              halt,
   input  logic [DATA_W-1:0] im_data,
   output logic [ADDR_W-1:0] im_addr,
   output logic              im_rd,
   output logic [DATA_W-1:0] out_to_IR,
   output logic              loadIR,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_LOAD   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   // Latency is limited to 1..4, so the wait counter fits in two bits.
   localparam logic [1:0]        CNT_INIT = 2'(IM_LATENCY - 1);
   localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_out;
   logic [1:0]        r_cnt;
   logic              r_jmp_pend;
   logic [ADDR_W-1:0] r_jmp_addr;
   logic              r_halt_pend;
   logic              w_busy;

   assign w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_LOAD);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            // halt wins over a simultaneous fetch request
            if (halt)          w_next_state = S_HALTED;
            else if (fetch_en) w_next_state = S_ISSUE;
         end
         S_ISSUE: w_next_state = S_WAIT;
         S_WAIT: begin
            if (r_cnt == 2'd0) w_next_state = S_LOAD;
         end
         S_LOAD: begin
            // A halt seen at any point during the fetch takes effect here.
            if (r_halt_pend || halt) w_next_state = S_HALTED;
            else                     w_next_state = S_IDLE;
         end
         S_HALTED: w_next_state = S_HALTED;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Program counter, wait counter, pending jump/halt
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= PC_INIT;
         r_cnt       <= 2'd0;
         r_jmp_pend  <= 1'b0;
         r_halt_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Loading here feeds the new address into a same-cycle fetch.
               if (!halt && pc_load) r_pc <= pc_load_addr;
            end
            S_ISSUE: begin
               r_cnt <= CNT_INIT;
            end
            S_WAIT: begin
               if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
            end
            S_LOAD: begin
               // A jump asserted in this very cycle is the latest one and wins.
               if (pc_load)         r_pc <= pc_load_addr;
               else if (r_jmp_pend) r_pc <= r_jmp_addr;
               else                 r_pc <= r_pc + 1'b1;  // wraps modulo 2^ADDR_W
               r_jmp_pend  <= 1'b0;
               r_halt_pend <= 1'b0;
            end
            default: ;
         endcase
         // Requests arriving mid-fetch are deferred to the LOAD cycle.
         if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
            if (pc_load) r_jmp_pend  <= 1'b1;
            if (halt)    r_halt_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pc_load && w_busy) r_jmp_addr <= pc_load_addr;
   end

   // Captured instruction word
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= '0;
      end else if ((r_state == S_WAIT) && (r_cnt == 2'd0)) begin
         r_out <= im_data;
      end
   end

   assign im_addr   = r_pc;
   assign pc        = r_pc;
   assign im_rd     = (r_state == S_ISSUE);
   assign loadIR    = (r_state == S_LOAD);
   assign busy      = w_busy;
   assign halted    = (r_state == S_HALTED);
   assign out_to_IR = r_out;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // DUT with IM_LATENCY=1
   logic        reset, fetch_en, pc_load, halt;
   logic [11:0] pc_load_addr;
   logic [15:0] im_data;
   logic [11:0] im_addr, pc;
   logic        im_rd, loadIR, busy, halted;
   logic [15:0] out_to_IR;

   // DUT with IM_LATENCY=3
   logic        rst3, fe3, pl3, hlt3;
   logic [11:0] pla3;
   logic [15:0] dat3;
   logic [11:0] ima3, pc3;
   logic        imrd3, ld3, busy3, halted3;
   logic [15:0] out3;

   int n_checks = 0;
   int n_err    = 0;

   instruction_fetch_unit #(.ADDR_W(12), .DATA_W(16), .IM_LATENCY(1), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_load(pc_load),
      .pc_load_addr(pc_load_addr), .halt(halt), .im_data(im_data),
      .im_addr(im_addr), .im_rd(im_rd), .out_to_IR(out_to_IR), .loadIR(loadIR),
      .pc(pc), .busy(busy), .halted(halted)
   );

   instruction_fetch_unit #(.ADDR_W(12), .DATA_W(16), .IM_LATENCY(3), .RESET_PC(0)) dut3 (
      .clk(clk), .reset(rst3), .fetch_en(fe3), .pc_load(pl3),
      .pc_load_addr(pla3), .halt(hlt3), .im_data(dat3),
      .im_addr(ima3), .im_rd(imrd3), .out_to_IR(out3), .loadIR(ld3),
      .pc(pc3), .busy(busy3), .halted(halted3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [15:0] words [3];

   initial begin
      words[0] = 16'h0001; words[1] = 16'h7777; words[2] = 16'h1234;
      reset = 1; fetch_en = 0; pc_load = 0; halt = 0; pc_load_addr = '0; im_data = '0;
      rst3 = 1; fe3 = 0; pl3 = 0; hlt3 = 0; pla3 = '0; dat3 = '0;
      step(); step();
      reset = 0;

      // Reset state
      chk("rst_pc", pc, 12'h000);
      chk("rst_im_rd", im_rd, 1'b0);
      chk("rst_loadIR", loadIR, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_out", out_to_IR, 16'h0000);

      // Single fetch, latency 3 cycles from fetch_en
      im_data = 16'hffff; fetch_en = 1;
      step();                                  // ISSUE
      fetch_en = 0;
      chk("f1_im_rd", im_rd, 1'b1);
      chk("f1_im_addr", im_addr, 12'h000);
      chk("f1_busy", busy, 1'b1);
      chk("f1_ld_c1", loadIR, 1'b0);
      step();                                  // WAIT
      chk("f1_ld_c2", loadIR, 1'b0);
      chk("f1_im_rd_c2", im_rd, 1'b0);
      step();                                  // LOAD
      chk("f1_ld_c3", loadIR, 1'b1);
      chk("f1_out", out_to_IR, 16'hffff);
      step();                                  // IDLE
      chk("f1_ld_c4", loadIR, 1'b0);
      chk("f1_pc", pc, 12'h001);
      chk("f1_busy_end", busy, 1'b0);
      chk("f1_out_hold", out_to_IR, 16'hffff);

      // Back-to-back fetches from a fresh reset; fetch_en held while busy
      reset = 1; step(); reset = 0;
      chk("b_rst_pc", pc, 12'h000);
      for (int i = 0; i < 3; i++) begin
         im_data = words[i]; fetch_en = 1;
         step();                               // ISSUE
         chk("b_im_rd", im_rd, 1'b1);
         chk("b_im_addr", im_addr, 32'(i));
         step();                               // WAIT, fetch_en still high
         chk("b_wait_rd", im_rd, 1'b0);
         step();                               // LOAD
         fetch_en = 0;
         chk("b_ld", loadIR, 1'b1);
         chk("b_out", out_to_IR, words[i]);
         step();                               // IDLE
         chk("b_ld_off", loadIR, 1'b0);
         chk("b_no_queue", im_rd, 1'b0);
         chk("b_idle", busy, 1'b0);
         chk("b_pc", pc, 32'(i + 1));
      end

      // Jump during WAIT: in-flight fetch completes at old address
      im_data = 16'hABCD; fetch_en = 1;
      step();                                  // ISSUE
      fetch_en = 0;
      chk("j_addr_old", im_addr, 12'h003);
      step();                                  // WAIT
      pc_load = 1; pc_load_addr = 12'h0FF;
      step();                                  // LOAD
      pc_load = 0; pc_load_addr = 12'h000;
      chk("j_ld", loadIR, 1'b1);
      chk("j_out", out_to_IR, 16'hABCD);
      chk("j_pc_hold", pc, 12'h003);
      step();                                  // IDLE
      chk("j_pc", pc, 12'h0FF);
      fetch_en = 1;
      step();
      fetch_en = 0;
      chk("j_next_addr", im_addr, 12'h0FF);
      chk("j_next_rd", im_rd, 1'b1);
      step(); step(); step();
      chk("j_next_pc", pc, 12'h100);

      // Jump and fetch together in IDLE, wrap at top of address space
      pc_load = 1; pc_load_addr = 12'hFFF; fetch_en = 1; im_data = 16'h2222;
      step();                                  // ISSUE
      pc_load = 0; fetch_en = 0;
      chk("w_addr", im_addr, 12'hFFF);
      step(); step();                          // LOAD
      chk("w_out", out_to_IR, 16'h2222);
      step();
      chk("w_pc_wrap", pc, 12'h000);

      // Halt during WAIT: current fetch still delivers, then HALTED
      im_data = 16'h5A5A; fetch_en = 1;
      step();
      fetch_en = 0;
      step();                                  // WAIT
      halt = 1;
      step();                                  // LOAD
      halt = 0;
      chk("h_ld", loadIR, 1'b1);
      chk("h_out", out_to_IR, 16'h5A5A);
      chk("h_not_yet", halted, 1'b0);
      step();
      chk("h_halted", halted, 1'b1);
      chk("h_busy", busy, 1'b0);
      chk("h_pc", pc, 12'h001);
      fetch_en = 1; pc_load = 1; pc_load_addr = 12'h123;
      step(); step();
      chk("h_no_rd", im_rd, 1'b0);
      chk("h_pc_frozen", pc, 12'h001);
      chk("h_sticky", halted, 1'b1);
      fetch_en = 0; pc_load = 0;
      reset = 1; step(); reset = 0;
      chk("h_rst_halted", halted, 1'b0);
      chk("h_rst_pc", pc, 12'h000);
      chk("h_rst_out", out_to_IR, 16'h0000);

      // halt has priority over fetch_en in IDLE
      halt = 1; fetch_en = 1;
      step();
      halt = 0; fetch_en = 0;
      chk("hp_halted", halted, 1'b1);
      chk("hp_no_rd", im_rd, 1'b0);
      reset = 1; step(); reset = 0;

      // IM_LATENCY=3: full fetch, then reset aborting a fetch in WAIT
      rst3 = 0;
      dat3 = 16'hBEEF; fe3 = 1;
      step();                                  // ISSUE
      fe3 = 0;
      chk("l3_rd", imrd3, 1'b1);
      step(); step(); step();                  // WAIT x3
      chk("l3_ld_early", ld3, 1'b0);
      chk("l3_busy", busy3, 1'b1);
      step();                                  // LOAD
      chk("l3_ld", ld3, 1'b1);
      chk("l3_out", out3, 16'hBEEF);
      step();
      chk("l3_pc", pc3, 12'h001);
      dat3 = 16'h4321; fe3 = 1;
      step();                                  // ISSUE
      fe3 = 0;
      step(); step();                          // WAIT (two of three)
      rst3 = 1;
      step();
      rst3 = 0;
      chk("a_ld", ld3, 1'b0);
      chk("a_rd", imrd3, 1'b0);
      chk("a_out", out3, 16'h0000);
      chk("a_pc", pc3, 12'h000);
      chk("a_busy", busy3, 1'b0);
      step(); step(); step();
      chk("a_no_ld_late", ld3, 1'b0);
      chk("a_out_late", out3, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Supply side of the instruction register: drives the instruction word and the loadIR strobe that the instruction_register consumes.
- Owns the program counter.
- On request from the control unit: reads the instruction memory at PC, waits a fixed latency, presents the word on out_to_IR, pulses loadIR for one cycle, then advances PC.
- Supports jumps (PC load) and a sticky halt.

Parameters:
ADDR_W, 12, program counter / instruction memory address width (matches the IR address field)
DATA_W, 16, instruction word width
IM_LATENCY, 1, cycles from the im_rd cycle to im_data being valid; legal range 1..4
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
fetch_en  input  1  control unit request for the next instruction; sampled only in IDLE
pc_load  input  1  load PC with pc_load_addr (jump/branch)
pc_load_addr  input  ADDR_W  jump target
halt  input  1  stop fetching; sticky until reset
im_data  input  DATA_W  instruction memory read data
im_addr  output  ADDR_W  instruction memory address
im_rd  output  1  instruction memory read strobe
out_to_IR  output  DATA_W  instruction word to the IR input in_from_IM
loadIR  output  1  one-cycle load strobe to the IR
pc  output  ADDR_W  current program counter
busy  output  1  fetch in progress
halted  output  1  unit in HALTED state

Behaviour:
- Reset (sampled high at an edge), from any state including mid-fetch:
  - state=IDLE, pc=RESET_PC, out_to_IR=0.
  - loadIR=0, im_rd=0, busy=0, halted=0, wait counter=0, pending jump cleared.
  - An aborted fetch never produces loadIR.
- FSM states: IDLE, ISSUE, WAIT, LOAD, HALTED.
- IDLE:
  - halt=1: go to HALTED. halt has priority over fetch_en.
  - Otherwise pc_load=1: pc<=pc_load_addr.
  - Otherwise fetch_en=1: go to ISSUE. If pc_load and fetch_en are both high, the fetch uses the new address.
- ISSUE (1 cycle):
  - im_rd=1, im_addr=pc. im_addr equals pc in all states; im_rd is high only in ISSUE.
  - Next state WAIT; counter loaded with IM_LATENCY-1.
- WAIT (IM_LATENCY cycles):
  - Counter decrements each cycle.
  - In the cycle the counter reads 0, im_data is valid: out_to_IR<=im_data at the end of that cycle, then go to LOAD.
- LOAD (1 cycle):
  - loadIR=1; out_to_IR holds the captured word.
  - At the end of the cycle: pc<=pending jump target if one is pending, else pc+1.
  - Next state: HALTED if a halt is pending, else IDLE.
- Latency: fetch_en sampled at edge E means ISSUE in cycle E+1 and loadIR high in cycle E+IM_LATENCY+2. With IM_LATENCY=1, that is 3 cycles.
- out_to_IR holds its value outside LOAD; it changes only on capture or reset.
- busy=1 in ISSUE, WAIT and LOAD; 0 otherwise.
- fetch_en while busy is ignored (no queuing); the control unit must re-assert it in IDLE.
- pc_load while busy:
  - Target is stored as pending and applied in LOAD instead of the increment.
  - The last assertion wins.
  - The in-flight fetch still completes with the old address.
- halt while busy: latched as pending; the current fetch completes (loadIR still pulses), then HALTED.
- HALTED: halted=1; pc frozen; fetch_en and pc_load ignored; exit only via reset.
- PC arithmetic: modulo 2^ADDR_W; 0xFFF+1 wraps to 0x000 with no flag.
- loadIR is never high for two consecutive cycles.

Test Plan:
- Reset, then fetch_en pulse, im_data=16'hffff, IM_LATENCY=1 -> im_rd high cycle 1 with im_addr=0x000; loadIR high cycle 3 only; out_to_IR=16'hffff; pc=0x001 afterwards.
- Three back-to-back fetches returning 16'h0001, 16'h7777, 16'h1234 -> loadIR pulses with matching out_to_IR; im_addr 0x000,0x001,0x002; fetch_en asserted while busy is ignored.
- pc_load with pc_load_addr=0x0FF in WAIT, im_data=16'hABCD -> loadIR still delivers 16'hABCD; pc becomes 0x0FF, not 0x001; next fetch has im_addr=0x0FF.
- pc_load to 0xFFF, fetch -> pc wraps to 0x000 after LOAD.
- halt in WAIT -> loadIR still pulses, then halted=1; later fetch_en produces no im_rd. Reset clears halted and sets pc=RESET_PC.
- Reset asserted during WAIT (IM_LATENCY=3) -> no loadIR; next cycle im_rd=0, out_to_IR=0, pc=0, busy=0.
